// File: rtl/ibex_register_file_rename.sv
// Renaming register file: architectural registers map onto a larger physical array,
// every write lands in a clean spare and the displaced entry is zeroised in the background.
module ibex_register_file_rename #(
  parameter bit                   RV32E        = 1'b0,
  parameter int                   DataWidth    = 32,
  parameter int                   NumSpare     = 2,
  parameter int                   NumReadPorts = 2,
  parameter logic [DataWidth-1:0] WordZeroVal  = '0
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumReadPorts*5-1:0]         raddr_i,
  output logic [NumReadPorts*DataWidth-1:0] rdata_o,
  input  logic [4:0]                        waddr_i,
  input  logic [DataWidth-1:0]              wdata_i,
  input  logic                              we_i,
  output logic                              wready_o,
  output logic                              busy_o
);

  localparam int NA = RV32E ? 16 : 32;
  localparam int AW = RV32E ? 4 : 5;
  localparam int NP = NA + NumSpare;
  localparam int PW = $clog2(NP);
  localparam int SW = (NumSpare > 1) ? $clog2(NumSpare) : 1;
  localparam int CW = $clog2(NumSpare + 1);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        map_q [NA];
  logic [DataWidth-1:0] phys_q [NP];
  logic [PW-1:0]        clean_fifo [NumSpare];
  logic [PW-1:0]        dirty_fifo [NumSpare];
  logic [SW-1:0]        clean_head, dirty_head;
  logic [CW-1:0]        clean_cnt, dirty_cnt;
  logic [PW-1:0]        init_cnt;

  logic [AW-1:0]        w_idx;
  logic                 w_zero;
  logic [PW-1:0]        clean_head_idx, dirty_head_idx;
  logic [SW-1:0]        clean_tail, dirty_tail;
  logic                 do_write, do_scrub;
  logic                 phys_we;
  logic [PW-1:0]        phys_waddr;
  logic [DataWidth-1:0] phys_wdata;

  // FIFO pointers wrap modulo NumSpare, which need not be a power of two.
  function automatic logic [SW-1:0] ptr_add(input logic [SW-1:0] p, input logic [CW-1:0] n);
    int s;
    s = int'(p) + int'(n);
    if (s >= NumSpare) s = s - NumSpare;
    return SW'(s);
  endfunction

  assign w_idx          = waddr_i[AW-1:0];
  assign w_zero         = (w_idx == '0);
  assign clean_head_idx = clean_fifo[clean_head];
  assign dirty_head_idx = dirty_fifo[dirty_head];
  assign clean_tail     = ptr_add(clean_head, clean_cnt);
  assign dirty_tail     = ptr_add(dirty_head, dirty_cnt);

  always_comb begin
    state_d    = state_q;
    busy_o     = 1'b0;
    wready_o   = 1'b0;
    do_write   = 1'b0;
    do_scrub   = 1'b0;
    phys_we    = 1'b0;
    phys_waddr = '0;
    phys_wdata = WordZeroVal;
    case (state_q)
      S_INIT: begin
        busy_o     = 1'b1;
        phys_we    = 1'b1;
        phys_waddr = init_cnt;
        if (init_cnt == PW'(NP - 1)) state_d = S_RUN;
      end
      S_RUN: begin
        wready_o = (clean_cnt != '0) || w_zero;
        do_write = we_i && wready_o && !w_zero;
        do_scrub = !do_write && (dirty_cnt != '0);
        // Single array write port: the architectural write always beats the scrubber.
        if (do_write) begin
          phys_we    = 1'b1;
          phys_waddr = clean_head_idx;
          phys_wdata = wdata_i;
        end else if (do_scrub) begin
          phys_we    = 1'b1;
          phys_waddr = dirty_head_idx;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_INIT;
      init_cnt   <= '0;
      clean_head <= '0;
      dirty_head <= '0;
      clean_cnt  <= CW'(NumSpare);
      dirty_cnt  <= '0;
      for (int i = 0; i < NA; i++) map_q[i] <= PW'(i);
      for (int k = 0; k < NumSpare; k++) begin
        clean_fifo[k] <= PW'(NA + k);
        dirty_fifo[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == S_INIT) init_cnt <= init_cnt + PW'(1);
      if (do_write) begin
        map_q[w_idx]           <= clean_head_idx;
        dirty_fifo[dirty_tail] <= map_q[w_idx];
        clean_head             <= ptr_add(clean_head, CW'(1));
        clean_cnt              <= clean_cnt - CW'(1);
        dirty_cnt              <= dirty_cnt + CW'(1);
      end else if (do_scrub) begin
        clean_fifo[clean_tail] <= dirty_head_idx;
        dirty_head             <= ptr_add(dirty_head, CW'(1));
        dirty_cnt              <= dirty_cnt - CW'(1);
        clean_cnt              <= clean_cnt + CW'(1);
      end
    end
  end

  // Storage carries no reset so it can map onto FPGA RAM; INIT clears it instead.
  always_ff @(posedge clk_i) begin
    if (phys_we && !rst_i) phys_q[phys_waddr] <= phys_wdata;
  end

  for (genvar p = 0; p < NumReadPorts; p++) begin : g_read
    logic [4:0]    ra;
    logic [AW-1:0] ri;
    assign ra = raddr_i[p*5 +: 5];
    assign ri = ra[AW-1:0];
    assign rdata_o[p*DataWidth +: DataWidth] =
        (state_q == S_INIT || ri == '0) ? WordZeroVal : phys_q[map_q[ri]];
  end

endmodule

// File: tb/tb_ibex_register_file_rename.sv
// Bench for ibex_register_file_rename: directed tables plus a long randomized run against
// an architectural-level model (register values and free/dirty spare counts).
module tb_ibex_register_file_rename;

  localparam int NumSpare = 2;
  localparam int NumPorts = 4;
  localparam int NA       = 32;
  localparam int NP       = NA + NumSpare;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic [NumPorts*5-1:0]  raddr_i;
  logic [NumPorts*32-1:0] rdata_o;
  logic [4:0]             waddr_i;
  logic [31:0]            wdata_i;
  logic                   we_i;
  logic                   wready_o;
  logic                   busy_o;

  always #5 clk_i = ~clk_i;

  ibex_register_file_rename #(
    .RV32E(1'b0), .DataWidth(32), .NumSpare(NumSpare), .NumReadPorts(NumPorts), .WordZeroVal('0)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .raddr_i(raddr_i), .rdata_o(rdata_o),
    .waddr_i(waddr_i), .wdata_i(wdata_i), .we_i(we_i), .wready_o(wready_o), .busy_o(busy_o)
  );

  int          tests = 0;
  int          fails = 0;
  logic [31:0] mregs [NA];
  int          mclean = 0, mdirty = 0, minit = 0;
  bit          mvalid = 1'b0;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        exp_wready;
  } wvec_t;

  typedef struct {
    logic [4:0]  ra;
    logic [31:0] exp;
  } rvec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic mwready(input logic [4:0] a);
    return (minit == 0) && (mclean > 0 || a == 5'd0);
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (minit > 0 || a == 5'd0) return '0;
    return mregs[a];
  endfunction

  function automatic logic [NumPorts*5-1:0] pack(input logic [4:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic applyStimulus(input logic rst, input logic we, input logic [4:0] wa,
                               input logic [31:0] wd, input logic [NumPorts*5-1:0] ra);
    rst_i   = rst;
    we_i    = we;
    waddr_i = wa;
    wdata_i = wd;
    raddr_i = ra;
  endtask

  // Compares every output against the model, then checks that each physical index is owned
  // by exactly one of: the map, the clean list or the dirty list.
  task automatic checkOutput();
    int seen [NP];
    int idx;
    bit ok;
    #1;
    if (!mvalid) return;
    check("busy", 32'(busy_o), 32'(minit > 0));
    check("wready", 32'(wready_o), 32'(mwready(waddr_i)));
    for (int p = 0; p < NumPorts; p++)
      check($sformatf("rdata%0d", p), rdata_o[p*32 +: 32], mread(raddr_i[p*5 +: 5]));
    check("clean_cnt", 32'(dut.clean_cnt), 32'(mclean));
    check("dirty_cnt", 32'(dut.dirty_cnt), 32'(mdirty));
    ok = 1'b1;
    foreach (seen[i]) seen[i] = 0;
    for (int r = 0; r < NA; r++) begin
      idx = int'(dut.map_q[r]);
      if (idx < NP) seen[idx]++; else ok = 1'b0;
    end
    for (int k = 0; k < int'(dut.clean_cnt); k++) begin
      idx = int'(dut.clean_fifo[(int'(dut.clean_head) + k) % NumSpare]);
      if (idx < NP) seen[idx]++; else ok = 1'b0;
    end
    for (int k = 0; k < int'(dut.dirty_cnt); k++) begin
      idx = int'(dut.dirty_fifo[(int'(dut.dirty_head) + k) % NumSpare]);
      if (idx < NP) seen[idx]++; else ok = 1'b0;
    end
    foreach (seen[i]) if (seen[i] != 1) ok = 1'b0;
    check("unique_phys", 32'(ok), 32'd1);
  endtask

  task automatic step(output logic acc);
    acc = we_i && mwready(waddr_i);
    @(posedge clk_i);
    if (rst_i) begin
      mvalid = 1'b1;
      minit  = NP;
      mclean = NumSpare;
      mdirty = 0;
      foreach (mregs[i]) mregs[i] = '0;
    end else if (!mvalid) begin
      acc = 1'b0;
    end else if (minit > 0) begin
      minit--;
    end else if (acc && waddr_i != 5'd0) begin
      mregs[waddr_i] = wdata_i;
      mclean--;
      mdirty++;
    end else if (mdirty > 0) begin
      mdirty--;
      mclean++;
    end
    @(negedge clk_i);
  endtask

  task automatic cycle(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [NumPorts*5-1:0] ra, output logic acc);
    applyStimulus(rst, we, wa, wd, ra);
    checkOutput();
    step(acc);
  endtask

  initial begin
    wvec_t       tput [6];
    rvec_t       rback [4];
    logic        acc, pend, r;
    logic [4:0]  pa;
    logic [31:0] pd;
    int          busy_count, old, nacc;

    tput[0] = '{1'b1, 5'd10, 32'hA000_000A, 1'b1};
    tput[1] = '{1'b1, 5'd11, 32'hB000_000B, 1'b1};
    tput[2] = '{1'b1, 5'd12, 32'hC000_000C, 1'b0};
    tput[3] = '{1'b1, 5'd12, 32'hC000_000C, 1'b1};
    tput[4] = '{1'b1, 5'd13, 32'hD000_000D, 1'b0};
    tput[5] = '{1'b1, 5'd13, 32'hD000_000D, 1'b1};
    rback[0] = '{5'd10, 32'hA000_000A};
    rback[1] = '{5'd11, 32'hB000_000B};
    rback[2] = '{5'd12, 32'hC000_000C};
    rback[3] = '{5'd13, 32'hD000_000D};

    applyStimulus(1'b1, 1'b0, 5'd0, '0, '0);
    step(acc);
    cycle(1'b1, 1'b0, 5'd0, '0, pack(1, 2, 3, 4), acc);

    // INIT: requests are offered throughout and must all be refused.
    busy_count = 0;
    for (int c = 0; c < NP + 2; c++) begin
      applyStimulus(1'b0, c < NP, 5'd5, 32'hAAAA_0000 + c,
                    pack(5'(c), 5'(c + 1), 5'(c + 7), 5'(31 - c)));
      checkOutput();
      if (busy_o === 1'b1) busy_count++;
      step(acc);
    end
    check("init_len", busy_count, NP);

    cycle(1'b0, 1'b1, 5'd5, 32'h5555_5555, pack(5, 0, 0, 0), acc);
    cycle(1'b0, 1'b0, 5'd0, '0, pack(5, 0, 0, 0), acc);
    cycle(1'b0, 1'b0, 5'd0, '0, pack(5, 0, 0, 0), acc);
    old = int'(dut.map_q[5]);
    cycle(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, pack(5, 5, 5, 5), acc);
    check("scrub_not_early", dut.phys_q[old], 32'h5555_5555);
    applyStimulus(1'b0, 1'b0, 5'd0, '0, pack(5, 5, 5, 5));
    checkOutput();
    check("x5_read", rdata_o[31:0], 32'hDEAD_BEEF);
    step(acc);
    check("scrub_old_phys", dut.phys_q[old], 32'h0);

    cycle(1'b0, 1'b0, 5'd0, '0, '0, acc);
    cycle(1'b0, 1'b0, 5'd0, '0, '0, acc);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, tput[i].we, tput[i].wa, tput[i].wd, pack(10, 11, 12, 13));
      checkOutput();
      check($sformatf("tput_wready%0d", i), 32'(wready_o), 32'(tput[i].exp_wready));
      step(acc);
    end
    cycle(1'b0, 1'b0, 5'd0, '0, '0, acc);
    cycle(1'b0, 1'b0, 5'd0, '0, '0, acc);
    applyStimulus(1'b0, 1'b0, 5'd0, '0, pack(rback[0].ra, rback[1].ra, rback[2].ra, rback[3].ra));
    checkOutput();
    for (int i = 0; i < 4; i++)
      check($sformatf("readback%0d", i), rdata_o[i*32 +: 32], rback[i].exp);
    step(acc);

    // x0 write with no clean spare; the cycle is idle for the scrubber.
    cycle(1'b0, 1'b1, 5'd1, 32'h0000_0101, '0, acc);
    cycle(1'b0, 1'b1, 5'd2, 32'h0000_0202, '0, acc);
    applyStimulus(1'b0, 1'b1, 5'd0, 32'h0000_1234, pack(0, 0, 0, 0));
    checkOutput();
    check("x0_clean_empty", 32'(dut.clean_cnt), 32'd0);
    check("x0_wready", 32'(wready_o), 32'd1);
    step(acc);
    applyStimulus(1'b0, 1'b0, 5'd0, '0, pack(0, 0, 0, 0));
    checkOutput();
    check("x0_read", rdata_o[31:0], 32'h0);
    check("x0_cnt_sum", 32'(dut.clean_cnt) + 32'(dut.dirty_cnt), NumSpare);
    check("x0_clean_cnt", 32'(dut.clean_cnt), 32'd1);
    step(acc);

    cycle(1'b0, 1'b0, 5'd0, '0, '0, acc);
    cycle(1'b0, 1'b1, 5'd7, 32'h11, '0, acc);
    cycle(1'b0, 1'b0, 5'd0, '0, '0, acc);
    cycle(1'b0, 1'b0, 5'd0, '0, '0, acc);
    applyStimulus(1'b0, 1'b1, 5'd7, 32'h22, pack(7, 7, 7, 7));
    checkOutput();
    for (int p = 0; p < NumPorts; p++) check($sformatf("x7_old%0d", p), rdata_o[p*32 +: 32], 32'h11);
    step(acc);
    applyStimulus(1'b0, 1'b0, 5'd0, '0, pack(7, 7, 7, 7));
    checkOutput();
    for (int p = 0; p < NumPorts; p++) check($sformatf("x7_new%0d", p), rdata_o[p*32 +: 32], 32'h22);
    step(acc);

    // Ten random writes, then a reset that collides with a pending write.
    pend = 1'b0; nacc = 0; pa = '0; pd = '0;
    for (int c = 0; c < 200 && nacc < 10; c++) begin
      if (!pend) begin pend = 1'b1; pa = 5'($urandom_range(31, 1)); pd = $urandom; end
      cycle(1'b0, pend, pa, pd, 20'($urandom), acc);
      if (acc) begin pend = 1'b0; nacc++; end
    end
    check("ten_writes", nacc, 10);
    cycle(1'b1, 1'b1, 5'd3, 32'h3333_3333, pack(3, 5, 7, 10), acc);
    for (int c = 0; c < NP; c++) cycle(1'b0, 1'b0, 5'd0, '0, 20'($urandom), acc);
    for (int g = 0; g < 8; g++) begin
      applyStimulus(1'b0, 1'b0, 5'd0, '0, pack(5'(g*4), 5'(g*4+1), 5'(g*4+2), 5'(g*4+3)));
      checkOutput();
      for (int p = 0; p < NumPorts; p++)
        check($sformatf("post_reset_zero_x%0d", g*4 + p), rdata_o[p*32 +: 32], 32'h0);
      step(acc);
    end

    pend = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (!pend && $urandom_range(2, 0) == 0) begin
        pend = 1'b1; pa = 5'($urandom_range(31, 0)); pd = $urandom;
      end
      r = ($urandom_range(2999, 0) == 0);
      cycle(r, pend, pa, pd, 20'($urandom), acc);
      if (acc || r) pend = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
